// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between CPU fetch and load/store ports,
// one outstanding transaction, data priority with a starvation bound for fetch.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_we,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);
    localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t                    state_q;
    logic [CW-1:0]             starve_q, starve_d;
    logic                      owner_q;
    logic                      mem_req_valid_q, mem_we_q;
    logic [ADDR_WIDTH-1:0]     mem_addr_q;
    logic [DATA_WIDTH-1:0]     mem_wdata_q;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb_q;
    logic                      if_rsp_valid_q, d_rsp_valid_q;
    logic [DATA_WIDTH-1:0]     if_rsp_data_q, d_rsp_data_q;
    logic                      grant_f, grant_d;
    // Data wins ties until fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_f  = state_q == IDLE && if_req_valid && (!d_req_valid || starve_q == LIMIT);
        grant_d  = state_q == IDLE && d_req_valid && !grant_f;
        starve_d = grant_f ? '0
                 : (grant_d && if_req_valid && starve_q != LIMIT) ? starve_q + CW'(1)
                 : starve_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            starve_q        <= '0;
            owner_q         <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
            if_rsp_valid_q  <= 1'b0;
            d_rsp_valid_q   <= 1'b0;
            if_rsp_data_q   <= '0;
            d_rsp_data_q    <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            starve_q       <= starve_d;
            case (state_q)
                IDLE: if (grant_f || grant_d) begin
                    state_q         <= ISSUE;
                    owner_q         <= grant_d;
                    mem_req_valid_q <= 1'b1;
                    mem_addr_q      <= grant_d ? d_addr : if_addr;
                    mem_we_q        <= grant_d && d_we;
                    mem_wdata_q     <= grant_d ? d_wdata : '0;
                    mem_wstrb_q     <= grant_d ? d_wstrb : '0;
                end
                ISSUE: if (mem_req_ready) begin
                    state_q         <= WAIT;
                    mem_req_valid_q <= 1'b0;
                end
                WAIT: if (mem_rsp_valid) begin
                    state_q <= IDLE;
                    if (owner_q) begin
                        d_rsp_valid_q <= 1'b1;
                        d_rsp_data_q  <= mem_we_q ? '0 : mem_rsp_data;
                    end else begin
                        if_rsp_valid_q <= 1'b1;
                        if_rsp_data_q  <= mem_rsp_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign if_req_ready  = grant_f;
    assign d_req_ready   = grant_d;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign d_rsp_valid   = d_rsp_valid_q;
    assign d_rsp_data    = d_rsp_data_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with scoreboard queues checked by a negedge monitor.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0, if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0, d_req_ready;
    logic [31:0] d_addr = '0;
    logic        d_we = 1'b0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_req_valid, mem_we;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data = '0;
    logic        rsp_q = 1'b0, mem_hold = 1'b0, inj = 1'b0;
    int          checks = 0, errors = 0;
    logic [68:0] exp_mem[$];
    logic [31:0] exp_if[$], exp_d[$];
    logic        exp_g[$];
    logic [68:0] me;
    logic [31:0] ed;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h4 ? 32'h00700393 : (32'hDEAD0000 | {16'h0, a[15:0]});
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: answers one cycle after each accepted request unless held off.
    always @(posedge clk) begin
        rsp_q <= mem_req_valid && mem_req_ready && !mem_hold;
        if (mem_req_valid && mem_req_ready) mem_rsp_data <= mem_word(mem_addr);
    end
    assign mem_rsp_valid = rsp_q | inj;

    always @(negedge clk) begin
        if (if_req_ready && d_req_ready) chk("both_ready", 1, 0);
        if (exp_g.size() > 0 && (if_req_ready || d_req_ready)) chk("grant_order", 96'(d_req_ready), 96'(exp_g.pop_front()));
        if (mem_req_valid && mem_req_ready) begin
            if (exp_mem.size() == 0) chk("mem_req_unexpected", 1, 0);
            else begin
                me = exp_mem.pop_front();
                chk("mem_req_fields", {mem_addr, mem_we, mem_wdata, mem_wstrb}, me);
            end
        end
        if (if_rsp_valid) begin
            if (exp_if.size() == 0) chk("if_rsp_unexpected", 1, 0);
            else begin
                ed = exp_if.pop_front();
                chk("if_rsp_data", if_rsp_data, ed);
            end
        end
        if (d_rsp_valid) begin
            if (exp_d.size() == 0) chk("d_rsp_unexpected", 1, 0);
            else begin
                ed = exp_d.pop_front();
                chk("d_rsp_data", d_rsp_data, ed);
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        int n = 0;
        if_req_valid = 1'b1;
        if_addr = a;
        @(negedge clk);
        while (!if_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("if_accept_timeout", 1, 0);
        else begin
            exp_mem.push_back({a, 1'b0, 32'h0, 4'h0});
            exp_if.push_back(mem_word(a));
        end
        @(posedge clk);
        #1 if_req_valid = 1'b0;
    endtask

    task automatic data(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
        int n = 0;
        d_req_valid = 1'b1;
        d_addr = a;
        d_we = we;
        d_wdata = wd;
        d_wstrb = ws;
        @(negedge clk);
        while (!d_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("d_accept_timeout", 1, 0);
        else begin
            exp_mem.push_back({a, we, wd, ws});
            exp_d.push_back(we ? 32'h0 : mem_word(a));
        end
        @(posedge clk);
        #1 d_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_if.size() + exp_d.size() + exp_mem.size() + exp_g.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", {mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb}, 0);
        chk("rst_rsp", {if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_data}, 0);
        chk("rst_ready", {if_req_ready, d_req_ready}, 0);
        // Single fetch with latency checks
        @(posedge clk);
        #1 if_req_valid = 1'b1;
        if_addr = 32'h4;
        @(negedge clk);
        chk("t1_if_ready_T", if_req_ready, 1);
        chk("t1_d_ready_T", d_req_ready, 0);
        exp_mem.push_back({32'h4, 1'b0, 32'h0, 4'h0});
        exp_if.push_back(32'h00700393);
        @(posedge clk);
        #1 if_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_mem_valid_T1", {mem_req_valid, mem_addr, mem_we}, {1'b1, 32'h4, 1'b0});
        @(negedge clk);
        chk("t1_T2", {mem_req_valid, if_rsp_valid}, 0);
        @(negedge clk);
        chk("t1_rsp_T3", {if_rsp_valid, if_rsp_data}, {1'b1, 32'h00700393});
        @(negedge clk);
        chk("t1_rsp_one_cycle", if_rsp_valid, 0);
        // Store ack
        @(posedge clk);
        #1 data(32'h100, 1'b1, 32'h51, 4'hF);
        drain();
        // Contention: D,D,D,D,F,D,D,D,D,F
        @(posedge clk);
        #1;
        foreach (exp_g[i]) exp_g.delete(i);
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        fork
            begin
                fetch(32'h10);
                fetch(32'h14);
            end
            begin
                for (int i = 0; i < 8; i++) data(32'h200 + 32'(4 * i), (i % 2) == 1, 32'h1000 + 32'(i), 4'hF);
            end
        join
        drain();
        // Memory backpressure with a pending data request
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        if_req_valid = 1'b1;
        if_addr = 32'h300;
        @(negedge clk);
        chk("t4_if_ready", if_req_ready, 1);
        exp_mem.push_back({32'h300, 1'b0, 32'h0, 4'h0});
        exp_if.push_back(mem_word(32'h300));
        @(posedge clk);
        #1 if_req_valid = 1'b0;
        d_req_valid = 1'b1;
        d_addr = 32'h400;
        d_we = 1'b0;
        d_wdata = 32'h0;
        d_wstrb = 4'h0;
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (i == 6) mem_req_ready = 1'b1;
            @(negedge clk);
            chk("t4_stall_hold", {mem_req_valid, mem_addr, d_req_ready, if_req_ready}, {1'b1, 32'h300, 2'b00});
        end
        @(negedge clk);
        chk("t4_req_dropped", mem_req_valid, 0);
        @(posedge clk);
        #1 data(32'h400, 1'b0, 32'h0, 4'h0);
        drain();
        // Reset while waiting for the memory response
        mem_hold = 1'b1;
        @(posedge clk);
        #1 if_req_valid = 1'b1;
        if_addr = 32'h500;
        @(negedge clk);
        chk("t5_if_ready", if_req_ready, 1);
        exp_mem.push_back({32'h500, 1'b0, 32'h0, 4'h0});
        @(posedge clk);
        #1 if_req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mem_hold = 1'b0;
        inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        @(negedge clk);
        chk("t5_mem_reset", {mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb}, 0);
        chk("t5_rsp_reset", {if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_data}, 0);
        chk("t5_ready_reset", {if_req_ready, d_req_ready}, 0);
        @(negedge clk);
        chk("t5_no_late_rsp", {if_rsp_valid, d_rsp_valid, mem_req_valid}, 0);
        @(posedge clk);
        #1 fetch(32'h4);
        drain();
        chk("end_if_queue", 96'(exp_if.size()), 0);
        chk("end_d_queue", 96'(exp_d.size()), 0);
        chk("end_mem_queue", 96'(exp_mem.size()), 0);
        chk("end_grant_queue", 96'(exp_g.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
